// File: rtl/my_err_gen_pkg.sv
// my_err_gen_pkg: shared state encoding, mode constants and saturation helper for the error generator
package my_err_gen_pkg;
  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    WAIT_L_TRIG = 4'd1,
    STABLE_L    = 4'd2,
    ACQ_L       = 4'd3,
    WAIT_H_TRIG = 4'd4,
    STABLE_H    = 4'd5,
    ACQ_H       = 4'd6,
    ERR_GEN     = 4'd7
  } state_t;
  localparam logic MODE_DIFF   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;
  // v carries an in_w-bit signed value; result is clamped to the signed out_w range
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int in_w, input int out_w);
    logic signed [63:0] x, hi, lo;
    x  = (v <<< (64 - in_w)) >>> (64 - in_w);
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return x > hi ? hi : x < lo ? lo : x;
  endfunction
endpackage

// File: rtl/my_err_avg_acc.sv
// my_err_avg_acc: accumulate/count/shift averager shared by the low and high acquisition phases
module my_err_avg_acc #(
  parameter int ADC_BIT = 14,
  parameter int MAX_AVG_SEL = 10,
  parameter int ERR_W = 32,
  parameter int SEL_W = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_clr,
  input  logic                      i_acq,
  input  logic [SEL_W-1:0]          i_sel,
  input  logic signed [ADC_BIT-1:0] i_data,
  output logic                      o_done,
  output logic signed [ERR_W-1:0]   o_avg
);
  localparam int ACC_W = ADC_BIT + MAX_AVG_SEL;
  localparam logic [MAX_AVG_SEL:0] ONE = 1;
  logic signed [ACC_W-1:0] acc_q, acc_d, sum;
  logic [MAX_AVG_SEL:0] cnt_q, cnt_d, last_idx;
  always_comb begin
    sum      = acc_q + ACC_W'(i_data);
    last_idx = (ONE << i_sel) - ONE;
    o_done   = i_acq && cnt_q == last_idx;
    // average includes the sample arriving this cycle so the phase needs no drain cycle
    o_avg    = ERR_W'(sum >>> i_sel);
    acc_d    = (i_clr || o_done) ? '0 : i_acq ? sum : acc_q;
    cnt_d    = (i_clr || o_done) ? '0 : i_acq ? cnt_q + ONE : cnt_q;
  end
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/my_err_signal_gen_v2.sv
// my_err_signal_gen_v2: square-wave error generator with settle, low/high averaging,
// offset correction, saturation and trigger-miss reporting
module my_err_signal_gen_v2
  import my_err_gen_pkg::*;
#(
  parameter int ADC_BIT = 14,
  parameter int MAX_AVG_SEL = 10,
  parameter int ERR_W = 32,
  parameter int SEL_W = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic                      i_mode,
  input  logic                      i_polarity,
  input  logic                      i_trig,
  input  logic [31:0]               i_wait_cnt,
  input  logic [SEL_W-1:0]          i_avg_sel,
  input  logic signed [ERR_W-1:0]   i_err_offset,
  input  logic signed [ADC_BIT-1:0] i_adc_data,
  output logic signed [ERR_W-1:0]   o_err,
  output logic                      o_err_vld,
  output logic                      o_sat,
  output logic                      o_trig_miss,
  output logic signed [ERR_W-1:0]   o_low_avg,
  output logic signed [ERR_W-1:0]   o_high_avg,
  output logic [3:0]                o_cstate
);
  localparam int XW = ERR_W + 2;
  state_t state_q, state_d;
  logic [31:0] wait_q, wait_d;
  logic mode_q, mode_d, pol_q, pol_d, vld_q, vld_d, sat_q, sat_d, miss_q, miss_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic signed [ERR_W-1:0] off_q, off_d, err_q, err_d, low_q, low_d, high_q, high_d, avg;
  logic signed [XW-1:0] diff, res;
  logic signed [63:0] res_w, clip;
  logic acq, done, busy;

  my_err_avg_acc #(
    .ADC_BIT(ADC_BIT), .MAX_AVG_SEL(MAX_AVG_SEL), .ERR_W(ERR_W), .SEL_W(SEL_W)
  ) u_acc (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(!i_en), .i_acq(acq),
    .i_sel(sel_q), .i_data(i_adc_data), .o_done(done), .o_avg(avg)
  );

  always_comb begin
    acq     = i_en && (state_q == ACQ_L || state_q == ACQ_H);
    busy    = state_q inside {STABLE_L, STABLE_H, ACQ_L, ACQ_H, ERR_GEN};
    diff    = mode_q == MODE_DIFF ? (pol_q ? XW'(low_q) - XW'(high_q) : XW'(high_q) - XW'(low_q))
                                  : (pol_q ? -XW'(low_q) : XW'(low_q));
    res     = diff + XW'(off_q);
    res_w   = 64'(res);
    clip    = sat_signed(res_w, XW, ERR_W);
    state_d = state_q;
    wait_d  = wait_q;
    mode_d  = mode_q;
    pol_d   = pol_q;
    sel_d   = sel_q;
    off_d   = off_q;
    err_d   = err_q;
    sat_d   = sat_q;
    low_d   = low_q;
    high_d  = high_q;
    vld_d   = 1'b0;
    miss_d  = i_en && i_trig && busy;
    if (!i_en) begin
      state_d = IDLE;
      wait_d  = '0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_L_TRIG;
        WAIT_L_TRIG: if (i_trig) begin
          // period configuration is frozen here until the next low trigger
          mode_d  = i_mode;
          pol_d   = i_polarity;
          sel_d   = i_avg_sel > SEL_W'(MAX_AVG_SEL) ? SEL_W'(MAX_AVG_SEL) : i_avg_sel;
          off_d   = i_err_offset;
          wait_d  = i_wait_cnt;
          state_d = STABLE_L;
        end
        WAIT_H_TRIG: if (i_trig) begin
          wait_d  = i_wait_cnt;
          state_d = STABLE_H;
        end
        STABLE_L, STABLE_H:
          if (wait_q == '0) state_d = state_q == STABLE_L ? ACQ_L : ACQ_H;
          else wait_d = wait_q - 32'd1;
        ACQ_L: if (done) begin
          low_d   = avg;
          state_d = mode_q == MODE_SINGLE ? ERR_GEN : WAIT_H_TRIG;
        end
        ACQ_H: if (done) begin
          high_d  = avg;
          state_d = ERR_GEN;
        end
        ERR_GEN: begin
          err_d   = ERR_W'(clip);
          sat_d   = clip != res_w;
          vld_d   = 1'b1;
          state_d = WAIT_L_TRIG;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      mode_q  <= 1'b0;
      pol_q   <= 1'b0;
      sel_q   <= '0;
      off_q   <= '0;
      err_q   <= '0;
      vld_q   <= 1'b0;
      sat_q   <= 1'b0;
      miss_q  <= 1'b0;
      low_q   <= '0;
      high_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      mode_q  <= mode_d;
      pol_q   <= pol_d;
      sel_q   <= sel_d;
      off_q   <= off_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      sat_q   <= sat_d;
      miss_q  <= miss_d;
      low_q   <= low_d;
      high_q  <= high_d;
    end

  assign o_err       = err_q;
  assign o_err_vld   = vld_q;
  assign o_sat       = sat_q;
  assign o_trig_miss = miss_q;
  assign o_low_avg   = low_q;
  assign o_high_avg  = high_q;
  assign o_cstate    = state_q;
endmodule

// File: tb/tb_my_err_signal_gen_v2.sv
// tb_my_err_signal_gen_v2: randomized bench with a behavioural period model, checking a 32-bit and a 16-bit instance
module tb_my_err_signal_gen_v2;
  localparam int K_CONST = 0, K_RND = 1, K_ALT = 2;
  logic i_clk = 1'b0;
  logic i_rst_n, i_en, i_mode, i_polarity, i_trig;
  logic [31:0] i_wait_cnt;
  logic [3:0] i_avg_sel;
  logic signed [31:0] off32;
  logic signed [15:0] off16;
  logic signed [13:0] adc;
  logic signed [31:0] err_a, low_a, high_a;
  logic signed [15:0] err_b, low_b, high_b;
  logic vld_a, sat_a, miss_a, vld_b, sat_b, miss_b;
  logic [3:0] cs_a, cs_b;
  int n_chk = 0, n_fail = 0, vld_cnt = 0;
  longint last32 = 0, last16 = 0;

  my_err_signal_gen_v2 #(.ERR_W(32)) dut_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_mode(i_mode), .i_polarity(i_polarity),
    .i_trig(i_trig), .i_wait_cnt(i_wait_cnt), .i_avg_sel(i_avg_sel), .i_err_offset(off32),
    .i_adc_data(adc), .o_err(err_a), .o_err_vld(vld_a), .o_sat(sat_a), .o_trig_miss(miss_a),
    .o_low_avg(low_a), .o_high_avg(high_a), .o_cstate(cs_a));

  my_err_signal_gen_v2 #(.ERR_W(16)) dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_mode(i_mode), .i_polarity(i_polarity),
    .i_trig(i_trig), .i_wait_cnt(i_wait_cnt), .i_avg_sel(i_avg_sel), .i_err_offset(off16),
    .i_adc_data(adc), .o_err(err_b), .o_err_vld(vld_b), .o_sat(sat_b), .o_trig_miss(miss_b),
    .o_low_avg(low_b), .o_high_avg(high_b), .o_cstate(cs_b));

  always #5 i_clk = ~i_clk;
  always @(negedge i_clk) if (vld_a) vld_cnt++;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_cs(input string tag, input int exp);
    chk({tag, "_a"}, longint'(cs_a), exp);
    chk({tag, "_b"}, longint'(cs_b), exp);
  endtask

  function automatic longint favg(input longint s, input longint n);
    return s >= 0 ? s / n : -((-s + n - 1) / n);
  endfunction

  function automatic longint clip(input longint v, input int w);
    longint mx = (longint'(1) << (w - 1)) - 1;
    return v > mx ? mx : v < -mx - 1 ? -mx - 1 : v;
  endfunction

  function automatic int samp(input int base, input int idx, input int kind);
    if (kind == K_RND) return int'($urandom_range(0, 16383)) - 8192;
    return (kind == K_ALT && idx % 2 == 1) ? base - 1 : base;
  endfunction

  task automatic junk_cfg;
    i_mode = 1'($urandom); i_polarity = 1'($urandom); i_avg_sel = 4'($urandom);
    off32 = 32'($urandom); off16 = 16'($urandom); i_wait_cnt = 32'($urandom);
  endtask

  // one full trigger period; ml/mh place a stray trigger in ACQ_L / STABLE_H (-1 = none)
  task automatic run(input bit m, input bit p, input int sel_in, input int off, input int w,
                     input int lv, input int hv, input int kind, input int ml, input int mh);
    int sel, n, v;
    longint ls, hs, la, ha, d, o32, o16, e32, e16;
    sel = sel_in > 10 ? 10 : sel_in;
    n = 1 << sel;
    ls = 0; hs = 0; ha = 0;
    i_mode = m; i_polarity = p; i_avg_sel = 4'(sel_in); off32 = off; off16 = 16'(off); i_wait_cnt = w;
    o32 = longint'(off32); o16 = longint'(off16);
    i_trig = 1'b1; tick; i_trig = 1'b0;
    chk_cs("stable_l", 2);
    junk_cfg;
    repeat (w + 1) begin adc = 14'($urandom); tick; end
    chk_cs("acq_l_start", 3);
    for (int i = 0; i < n; i++) begin
      v = samp(lv, i, kind); ls += v; adc = 14'(v);
      i_trig = (i == ml); tick; i_trig = 1'b0;
      if (i == ml) chk("miss_acq_l", miss_a, 1);
      if (i == n - 2) chk_cs("acq_l_run", 3);
    end
    la = favg(ls, n);
    chk("low_avg_a", low_a, la);
    chk("low_avg_b", low_b, la);
    if (!m) begin
      chk_cs("wait_h", 4);
      repeat ($urandom_range(0, 3)) begin adc = 14'($urandom); tick; end
      i_wait_cnt = w; i_trig = 1'b1; tick; i_trig = 1'b0;
      chk_cs("stable_h", 5);
      i_wait_cnt = 32'($urandom);
      for (int j = 0; j <= w; j++) begin
        adc = 14'($urandom); i_trig = (j == mh); tick; i_trig = 1'b0;
        if (j == mh) chk("miss_stable_h", miss_a, 1);
      end
      chk_cs("acq_h_start", 6);
      for (int i = 0; i < n; i++) begin
        v = samp(hv, i, kind); hs += v; adc = 14'(v); tick;
      end
      ha = favg(hs, n);
      chk("high_avg_a", high_a, ha);
      chk("high_avg_b", high_b, ha);
    end
    chk_cs("err_gen", 7);
    chk("vld_early", vld_a, 0);
    d = m ? (p ? -la : la) : (p ? la - ha : ha - la);
    e32 = d + o32; e16 = d + o16;
    adc = 14'($urandom); tick;
    last32 = clip(e32, 32); last16 = clip(e16, 16);
    chk("vld_a", vld_a, 1);
    chk("vld_b", vld_b, 1);
    chk("err_a", err_a, last32);
    chk("sat_a", sat_a, longint'(last32 != e32));
    chk("err_b", err_b, last16);
    chk("sat_b", sat_b, longint'(last16 != e16));
    tick;
    chk("vld_drop", vld_a, 0);
    chk_cs("back_wait_l", 1);
  endtask

  initial begin
    int v0;
    i_rst_n = 1'b0; i_en = 1'b0; i_trig = 1'b0; i_mode = 1'b0; i_polarity = 1'b0;
    i_wait_cnt = '0; i_avg_sel = '0; off32 = '0; off16 = '0; adc = '0;
    repeat (2) tick;
    chk("rst_err", err_a, 0);
    chk("rst_vld", vld_a, 0);
    chk("rst_low", low_a, 0);
    chk_cs("rst_state", 0);
    i_rst_n = 1'b1; i_en = 1'b1; tick;
    chk_cs("idle_to_wait", 1);

    run(0, 0, 2, 0, 3, 100, 300, K_CONST, -1, -1);
    run(0, 1, 2, -50, 3, 100, 300, K_CONST, -1, -1);
    run(1, 0, 1, 0, 2, -3, 0, K_ALT, -1, -1);
    run(0, 0, 0, 20000, 1, -8192, 8191, K_CONST, -1, -1);
    run(0, 1, 0, -20000, 1, -8192, 8191, K_CONST, -1, -1);
    run(0, 0, 1, 2147483647, 0, -8192, 8191, K_CONST, -1, -1);
    run(0, 0, 15, 0, 2, 77, 77, K_CONST, -1, -1);
    run(0, 0, 2, 0, 3, 100, 300, K_CONST, 1, 2);
    run(1, 1, 3, 0, 2, 500, 0, K_CONST, 5, -1);

    // enable dropped in the middle of the high acquisition
    i_mode = 1'b0; i_polarity = 1'b0; i_avg_sel = 4'd2; off32 = '0; off16 = '0; i_wait_cnt = 32'd1;
    i_trig = 1'b1; tick; i_trig = 1'b0;
    repeat (2) tick;
    repeat (4) begin adc = 14'(10); tick; end
    i_trig = 1'b1; tick; i_trig = 1'b0;
    repeat (2) tick;
    repeat (2) begin adc = 14'(20); tick; end
    chk_cs("en_pre_drop", 6);
    v0 = vld_cnt;
    i_en = 1'b0; tick;
    chk_cs("en_drop_idle", 0);
    chk("en_drop_vld", vld_a, 0);
    chk("en_drop_err_a", err_a, last32);
    chk("en_drop_err_b", err_b, last16);
    chk("en_drop_low", low_a, 10);
    i_en = 1'b1; tick;
    chk_cs("en_resume", 1);
    repeat (4) tick;
    chk("en_no_vld", vld_cnt - v0, 0);

    // synchronous reset while settling
    i_wait_cnt = 32'd5; i_trig = 1'b1; tick; i_trig = 1'b0; tick;
    chk_cs("pre_rst", 2);
    i_rst_n = 1'b0; tick;
    chk_cs("mid_rst_state", 0);
    chk("mid_rst_err", err_a, 0);
    chk("mid_rst_sat", sat_a, 0);
    chk("mid_rst_low", low_a, 0);
    chk("mid_rst_high", high_a, 0);
    chk("mid_rst_miss", miss_a, 0);
    chk("mid_rst_vld", vld_a, 0);
    i_rst_n = 1'b1; tick;
    chk_cs("post_rst", 1);

    for (int k = 0; k < 16; k++)
      run(1'($urandom), 1'($urandom), $urandom_range(0, 4),
          (k % 4 == 3) ? int'($urandom) : int'($urandom_range(0, 40000)) - 20000,
          $urandom_range(0, 4), 0, 0, K_RND,
          (k % 3 == 0) ? int'($urandom_range(0, 1)) : -1, (k % 3 == 1) ? 0 : -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
